// File: rtl/tdc_hit_sequencer.sv
// tdc_hit_sequencer
// Sequencing controller for the multiplexer-chain TDC delay line. It gates the
// filtered hit into the chain and decodes the registered tap vector into a
// ones-count fine code. It pairs the fine code with a free-running coarse counter
// and presents the timestamp on a valid/ready handshake. After each hit it
// enforces a dead time and a line flush before re-arming.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   arm             level enable for acquisition
//   clr             synchronous clear of miss_cnt
//   hit_sync        hit synchronised to clk, used only for miss counting
//   taps_q          registered delay-line taps, bit 0 is the first tap
//   hit_en          registered gate enable for the delay-line input
//   ts_valid/ready  timestamp handshake
//   ts_coarse       coarse count at the capture cycle
//   ts_fine         number of ones in taps_q at the capture cycle
//   ts_ovf          all taps were one at capture
//   miss_cnt        saturating count of hits seen while the gate was closed
//   busy            sequencer is not idle
module tdc_hit_sequencer #(
    parameter int unsigned NMUX        = 8,
    parameter int unsigned COARSE_W    = 16,
    parameter int unsigned DEAD_CYCLES = 4,
    localparam int unsigned FINE_W     = $clog2(NMUX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                clr,
    input  logic                hit_sync,
    input  logic [NMUX-1:0]     taps_q,
    output logic                hit_en,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_ovf,
    output logic [15:0]         miss_cnt,
    output logic                busy
);

    localparam int unsigned DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StArmed, StOutput, StDead, StFlush} state_e;

    state_e              state_q, state_d;
    logic                hit_en_q;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [COARSE_W-1:0] coarse_q;
    logic [COARSE_W-1:0] ts_coarse_q;
    logic [FINE_W-1:0]   ts_fine_q;
    logic                ts_ovf_q;
    logic [15:0]         miss_cnt_q, miss_cnt_d;
    logic                hit_sync_q;
    logic [FINE_W-1:0]   fine_cnt;
    logic                capture;
    logic                accept;
    logic                miss_inc;

    // arm has priority over a simultaneous first-tap hit
    assign capture  = (state_q == StArmed) && arm && taps_q[0];
    assign accept   = (state_q == StOutput) && ts_ready;
    assign miss_inc = hit_sync && !hit_sync_q && arm && (state_q != StArmed);

    // Ones count rather than thermometer decode so bubbles still give a sane code
    always_comb begin
        fine_cnt = '0;
        for (int unsigned i = 0; i < NMUX; i++) begin
            fine_cnt = fine_cnt + FINE_W'(taps_q[i]);
        end
    end

    // State register; hit_en is registered from the next state so it tracks ARMED exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            hit_en_q <= 1'b0;
            dead_q   <= '0;
        end else begin
            state_q  <= state_d;
            hit_en_q <= (state_d == StArmed);
            dead_q   <= dead_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        unique case (state_q)
            StIdle: begin
                if (arm) state_d = StArmed;
            end
            StArmed: begin
                if (!arm)         state_d = StIdle;
                else if (capture) state_d = StOutput;
            end
            StOutput: begin
                if (accept) begin
                    state_d = StDead;
                    dead_d  = DEAD_W'(DEAD_CYCLES - 1);
                end
            end
            StDead: begin
                if (dead_q == '0) state_d = StFlush;
                else              dead_d  = dead_q - DEAD_W'(1);
            end
            StFlush: begin
                if (taps_q == '0) state_d = arm ? StArmed : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        hit_en    = hit_en_q;
        ts_valid  = (state_q == StOutput);
        busy      = (state_q != StIdle);
        ts_coarse = ts_coarse_q;
        ts_fine   = ts_fine_q;
        ts_ovf    = ts_ovf_q;
        miss_cnt  = miss_cnt_q;
    end

    // Coarse counter and timestamp capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coarse_q    <= '0;
            ts_coarse_q <= '0;
            ts_fine_q   <= '0;
            ts_ovf_q    <= 1'b0;
        end else begin
            coarse_q <= coarse_q + COARSE_W'(1);
            if (capture) begin
                ts_coarse_q <= coarse_q;
                ts_fine_q   <= fine_cnt;
                ts_ovf_q    <= &taps_q;
            end
        end
    end

    // Miss counter: clr wins, saturates at all ones
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if (clr)                                  miss_cnt_d = '0;
        else if (miss_inc && miss_cnt_q != '1)    miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt_q <= '0;
            hit_sync_q <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            hit_sync_q <= hit_sync;
        end
    end

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
module tb_tdc_hit_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        clr;
    logic        hit_sync;
    logic [7:0]  taps_q;
    logic        hit_en;
    logic        ts_valid;
    logic        ts_ready;
    logic [15:0] ts_coarse;
    logic [3:0]  ts_fine;
    logic        ts_ovf;
    logic [15:0] miss_cnt;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference coarse counter
    logic [15:0] exp_coarse;

    tdc_hit_sequencer #(
        .NMUX        (8),
        .COARSE_W    (16),
        .DEAD_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .clr       (clr),
        .hit_sync  (hit_sync),
        .taps_q    (taps_q),
        .hit_en    (hit_en),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .ts_coarse (ts_coarse),
        .ts_fine   (ts_fine),
        .ts_ovf    (ts_ovf),
        .miss_cnt  (miss_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) exp_coarse <= 16'h0000;
        else     exp_coarse <= exp_coarse + 16'h0001;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; clr = 1'b0; hit_sync = 1'b0; taps_q = 8'h00; ts_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (hit_en !== 1'b0 || ts_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: got en=%b v=%b busy=%b expected 0 0 0", hit_en, ts_valid, busy);
            n_fail++;
        end
        n_checks++;
        if (ts_coarse !== 16'h0 || ts_fine !== 4'h0 || ts_ovf !== 1'b0 || miss_cnt !== 16'h0) begin
            $display("FAIL reset_data: got c=%h f=%h o=%b m=%h expected zeros",
                     ts_coarse, ts_fine, ts_ovf, miss_cnt);
            n_fail++;
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int guard = 0;
        arm = 1'b1;
        tick();
        n_checks++;
        if (hit_en !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL arm_latency: got en=%b busy=%b expected 1 1", hit_en, busy);
            n_fail++;
        end
        while (exp_coarse != 16'h0010 && guard < 100) begin
            tick();
            guard++;
        end
        n_checks++;
        if (exp_coarse !== 16'h0010) begin
            $display("FAIL basic_timeout: got %h expected 0010", exp_coarse);
            n_fail++;
        end
        taps_q = 8'h07;
        ts_ready = 1'b0;
        tick();
        taps_q = 8'h00;
        n_checks++;
        if (ts_valid !== 1'b1 || ts_coarse !== 16'h0010 || ts_fine !== 4'd3 || ts_ovf !== 1'b0 ||
            hit_en !== 1'b0) begin
            $display("FAIL basic_capture: got v=%b c=%h f=%0d o=%b en=%b expected 1 0010 3 0 0",
                     ts_valid, ts_coarse, ts_fine, ts_ovf, hit_en);
            n_fail++;
        end
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        n_checks++;
        if (ts_valid !== 1'b0) begin
            $display("FAIL basic_one_cycle_valid: got %b expected 0", ts_valid);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (hit_en !== 1'b0) begin
            $display("FAIL basic_dead_gate: got %b expected 0 at capture+5", hit_en);
            n_fail++;
        end
        tick();
        n_checks++;
        if (hit_en !== 1'b1) begin
            $display("FAIL basic_rearm: got %b expected 1 at capture+6", hit_en);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] cap_c;
        cap_c = exp_coarse;
        taps_q = 8'h05;
        ts_ready = 1'b0;
        tick();
        taps_q = 8'h00;
        for (int i = 0; i < 10; i++) begin
            hit_sync = (i == 3);
            n_checks++;
            if (ts_valid !== 1'b1 || ts_coarse !== cap_c || ts_fine !== 4'd2 || ts_ovf !== 1'b0 ||
                hit_en !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: got v=%b c=%h f=%0d o=%b en=%b expected 1 %h 2 0 0",
                         i, ts_valid, ts_coarse, ts_fine, ts_ovf, hit_en, cap_c);
                n_fail++;
            end
            tick();
        end
        hit_sync = 1'b0;
        n_checks++;
        if (miss_cnt !== 16'd1) begin
            $display("FAIL bp_miss: got %0d expected 1", miss_cnt);
            n_fail++;
        end
        ts_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (hit_en !== 1'b1) begin
            $display("FAIL bp_rearm: got %b expected 1", hit_en);
            n_fail++;
        end
    endtask

    task automatic test_overflow_bubble();
        taps_q = 8'hFF;
        tick();
        taps_q = 8'h00;
        n_checks++;
        if (ts_valid !== 1'b1 || ts_fine !== 4'd8 || ts_ovf !== 1'b1) begin
            $display("FAIL ovf: got v=%b f=%0d o=%b expected 1 8 1", ts_valid, ts_fine, ts_ovf);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) tick();
        taps_q = 8'h0B;
        tick();
        taps_q = 8'h00;
        n_checks++;
        if (ts_valid !== 1'b1 || ts_fine !== 4'd3 || ts_ovf !== 1'b0) begin
            $display("FAIL bubble: got v=%b f=%0d o=%b expected 1 3 0", ts_valid, ts_fine, ts_ovf);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_flush_hold();
        taps_q = 8'h01;
        tick();
        tick();
        taps_q = 8'h80;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (hit_en !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL flush_hold[%0d]: got en=%b busy=%b expected 0 1", i, hit_en, busy);
                n_fail++;
            end
        end
        taps_q = 8'h00;
        tick();
        n_checks++;
        if (hit_en !== 1'b1) begin
            $display("FAIL flush_release: got %b expected 1", hit_en);
            n_fail++;
        end
    endtask

    task automatic test_arm_corners();
        int guard = 0;
        arm = 1'b0;
        taps_q = 8'h01;
        tick();
        taps_q = 8'h00;
        n_checks++;
        if (ts_valid !== 1'b0 || hit_en !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL arm_wins: got v=%b en=%b busy=%b expected 0 0 0", ts_valid, hit_en, busy);
            n_fail++;
        end
        arm = 1'b1;
        tick();
        taps_q = 8'h01;
        tick();
        taps_q = 8'h00;
        tick();
        arm = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL dead_no_abort: got busy=%b expected 1", busy);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (busy !== 1'b0 || hit_en !== 1'b0) begin
            $display("FAIL dead_to_idle: got busy=%b en=%b expected 0 0", busy, hit_en);
            n_fail++;
        end
        arm = 1'b1;
        tick();
        while (exp_coarse != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        n_checks++;
        if (exp_coarse !== 16'hFFFF) begin
            $display("FAIL wrap_timeout: got %h expected FFFF", exp_coarse);
            n_fail++;
        end
        taps_q = 8'h01;
        tick();
        taps_q = 8'h00;
        n_checks++;
        if (ts_valid !== 1'b1 || ts_coarse !== 16'hFFFF) begin
            $display("FAIL wrap_capture: got v=%b c=%h expected 1 FFFF", ts_valid, ts_coarse);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_saturation();
        taps_q = 8'h01;
        ts_ready = 1'b0;
        tick();
        taps_q = 8'h00;
        force dut.miss_cnt_q = 16'hFFFF;
        tick();
        release dut.miss_cnt_q;
        hit_sync = 1'b1;
        tick();
        hit_sync = 1'b0;
        tick();
        n_checks++;
        if (miss_cnt !== 16'hFFFF) begin
            $display("FAIL miss_saturate: got %h expected FFFF", miss_cnt);
            n_fail++;
        end
        clr = 1'b1;
        hit_sync = 1'b1;
        tick();
        clr = 1'b0;
        hit_sync = 1'b0;
        n_checks++;
        if (miss_cnt !== 16'h0000) begin
            $display("FAIL clr_priority: got %h expected 0000", miss_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        n_checks++;
        if (ts_valid !== 1'b1) begin
            $display("FAIL mid_pre: got v=%b expected 1", ts_valid);
            n_fail++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ts_valid !== 1'b0 || hit_en !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL mid_reset: got v=%b en=%b busy=%b expected 0 0 0", ts_valid, hit_en, busy);
            n_fail++;
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow_bubble();
        test_flush_hold();
        test_arm_corners();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
